// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Frame layout on the wire after the start bit: data[7:0], odd parity, stop.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK_BYTE   = 8'hFA;

    localparam int FRAME_BITS = 10;

    // Bit 9 is the stop bit (line released), bit 8 makes the total count of ones odd.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one PS/2 pad.
// The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] run_cnt;

    // The idle bus is high, so the synchronizer and filter come out of reset at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            run_cnt <= '0;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= pad;
            sync_q2 <= sync_q1;
            fall    <= 1'b0;
            if (sync_q2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                run_cnt <= '0;
                level   <= sync_q2;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift the
// frame on device clock falls, then check the device acknowledge bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_HOLD     = 20,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e            state;
    ps2_state_e            next_state;
    logic [PW-1:0]         phase_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            bit_idx;
    logic                  data_drive;
    logic                  data_s1;
    logic                  data_s2;
    logic                  clk_level;
    logic                  clk_fall;
    logic                  phase_end;
    logic                  timeout;
    logic                  tmo_run;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .pad  (ps2_clk_in),
        .level(clk_level),
        .fall (clk_fall)
    );

    // Data is only ever sampled well after the filtered clock edge, so no glitch filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    assign phase_end = ((state == INHIBIT) && (phase_cnt == PW'(INHIBIT_CYCLES - 1))) ||
                       ((state == START)   && (phase_cnt == PW'(START_HOLD - 1)));
    assign tmo_run   = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign timeout   = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            tmo_cnt    <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            data_drive <= 1'b0;
        end else begin
            state <= next_state;

            if ((state == IDLE) && tx_valid) begin
                frame <= build_frame(tx_data);
            end

            if (((state == INHIBIT) || (state == START)) && !phase_end) begin
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
            end

            // Armed at zero on the first SHIFT cycle, i.e. the cycle the clock is released.
            if (tmo_run) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (state == START) begin
                data_drive <= 1'b1;
                bit_idx    <= '0;
            end else if (state == SHIFT) begin
                if (clk_fall) begin
                    data_drive <= ~frame[bit_idx];
                    bit_idx    <= bit_idx + 1'b1;
                end
            end else begin
                data_drive <= 1'b0;
                bit_idx    <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (tx_valid) next_state = INHIBIT;
            INHIBIT:   if (phase_end) next_state = START;
            START:     if (phase_end) next_state = SHIFT;
            SHIFT: begin
                if (timeout) next_state = ERR;
                else if (clk_fall && (bit_idx == 4'(FRAME_BITS - 1))) next_state = ACK;
            end
            ACK: begin
                if (timeout) next_state = ERR;
                else if (clk_fall) next_state = data_s2 ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (timeout) next_state = ERR;
                else if (clk_level && data_s2) next_state = DONE;
            end
            DONE:      next_state = IDLE;
            ERR:       next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_ready    = 1'b0;
        busy        = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE:      tx_ready = 1'b1;
            INHIBIT: begin
                busy       = 1'b1;
                ps2_clk_oe = 1'b1;
            end
            START: begin
                busy        = 1'b1;
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            SHIFT: begin
                busy        = 1'b1;
                ps2_data_oe = data_drive;
            end
            ACK:       busy = 1'b1;
            WAIT_IDLE: busy = 1'b1;
            DONE:      done = 1'b1;
            ERR:       err  = 1'b1;
            default:   tx_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus and a PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT_CYCLES = 200;
    localparam int START_HOLD     = 20;
    localparam int TIMEOUT_CYCLES = 3000;
    localparam int FILTER_LEN     = 8;
    localparam int HALF           = 40;
    localparam int NVEC           = 6;

    typedef struct {
        logic [7:0] data;
        bit         ack_bad;
        int         glitch;
        logic [9:0] frame;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT_CYCLES),
        .START_HOLD    (START_HOLD),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    // Monitor: pattern counters sampled on the falling clock edge
    bit   mon_clr = 1'b0;
    int   cyc, n_inhib, n_start, n_done, n_err, n_accept, t_rel, t_err;
    logic prev_clk_oe, prev_ready, prev_err, prev_done;
    logic err_oe, ready_after_err, ready_after_done;

    always @(negedge clk) begin
        if (mon_clr) begin
            cyc <= 0; n_inhib <= 0; n_start <= 0; n_done <= 0; n_err <= 0;
            n_accept <= 0; t_rel <= -1; t_err <= -1;
            err_oe <= 1'b1; ready_after_err <= 1'b0; ready_after_done <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (ps2_clk_oe && !ps2_data_oe) n_inhib <= n_inhib + 1;
            if (ps2_clk_oe && ps2_data_oe) n_start <= n_start + 1;
            if (done) n_done <= n_done + 1;
            if (err) begin
                n_err  <= n_err + 1;
                err_oe <= ps2_clk_oe | ps2_data_oe;
                if (t_err < 0) t_err <= cyc;
            end
            if (prev_clk_oe && !ps2_clk_oe && t_rel < 0) t_rel <= cyc;
            if (prev_ready && !tx_ready) n_accept <= n_accept + 1;
            if (prev_err) ready_after_err <= tx_ready;
            if (prev_done) ready_after_done <= tx_ready;
        end
        prev_clk_oe <= ps2_clk_oe;
        prev_ready  <= tx_ready;
        prev_err    <= err;
        prev_done   <= done;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic request(input logic [7:0] d, output bit ok);
        int w = 0;
        while (!tx_ready && w < 100) begin
            tick();
            w++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        ok = (w < 100);
    endtask

    // Device model: waits for request-to-send, clocks 11 pulses, reads bits before each rise.
    task automatic device_xfer(input bit ack_bad, input int glitch_pulse, input int rst_fall,
                               output logic [9:0] bits, output bit started);
        int w = 0;
        bits    = '0;
        started = 1'b0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) &&
               w < INHIBIT_CYCLES + START_HOLD + 100) begin
            tick();
            w++;
        end
        if (w >= INHIBIT_CYCLES + START_HOLD + 100) return;
        started = 1'b1;
        repeat (HALF) tick();
        for (int p = 1; p <= 11; p++) begin
            dev_clk = 1'b0;
            for (int t = 0; t < HALF; t++) begin
                if (p == rst_fall && t == FILTER_LEN + 6) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
                    check("rst_mid_data_oe", ps2_data_oe, 1'b0);
                    check("rst_mid_busy", busy, 1'b0);
                    check("rst_mid_tx_ready", tx_ready, 1'b1);
                    dev_clk  = 1'b1;
                    dev_data = 1'b1;
                    return;
                end
                tick();
            end
            if (p <= 10) bits[p-1] = ps2_data_line;
            dev_clk = 1'b1;
            if (p == 11) dev_data = 1'b1;
            for (int t = 0; t < HALF; t++) begin
                if (p == glitch_pulse && t == HALF / 2) dev_clk = 1'b0;
                if (p == glitch_pulse && t == HALF / 2 + 3) dev_clk = 1'b1;
                if (p == 10 && !ack_bad && t == HALF / 2) dev_data = 1'b0;
                tick();
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit         ok;
        bit         started;
        logic [9:0] bits;
        logic [9:0] exp_frame;
        mon_clear();
        exp_q.push_back(v.frame);
        request(v.data, ok);
        check($sformatf("v%0d_accept", idx), ok, 1'b1);
        check($sformatf("v%0d_ready_drop", idx), tx_ready, 1'b0);
        check($sformatf("v%0d_busy", idx), busy, 1'b1);
        device_xfer(v.ack_bad, v.glitch, 0, bits, started);
        check($sformatf("v%0d_dev_start", idx), started, 1'b1);
        repeat (5) tick();
        exp_frame = exp_q.pop_front();
        check($sformatf("v%0d_frame", idx), bits, exp_frame);
        check($sformatf("v%0d_inhibit_len", idx), n_inhib, INHIBIT_CYCLES);
        check($sformatf("v%0d_start_len", idx), n_start, START_HOLD);
        check($sformatf("v%0d_done_cnt", idx), n_done, v.exp_done);
        check($sformatf("v%0d_err_cnt", idx), n_err, v.exp_err);
        check($sformatf("v%0d_idle_ready", idx), tx_ready, 1'b1);
        check($sformatf("v%0d_idle_oe", idx), {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
        if (v.exp_err) begin
            check($sformatf("v%0d_err_oe", idx), err_oe, 1'b0);
            check($sformatf("v%0d_ready_after_err", idx), ready_after_err, 1'b1);
        end else begin
            check($sformatf("v%0d_ready_after_done", idx), ready_after_done, 1'b1);
        end
    endtask

    vec_t vecs[NVEC];

    initial begin
        bit         ok;
        bit         started;
        logic [9:0] bits;
        logic [9:0] exp_frame;
        int         w;

        // frame = {stop, odd parity, data}
        vecs[0] = '{CMD_ENABLE, 1'b0, 0, 10'h2F4, 1'b1, 1'b0};
        vecs[1] = '{CMD_RESET,  1'b0, 0, 10'h3FF, 1'b1, 1'b0};
        vecs[2] = '{CMD_ENABLE, 1'b1, 0, 10'h2F4, 1'b0, 1'b1};
        vecs[3] = '{8'h00,      1'b0, 0, 10'h300, 1'b1, 1'b0};
        vecs[4] = '{ACK_BYTE,   1'b0, 0, 10'h3FA, 1'b1, 1'b0};
        vecs[5] = '{8'h80,      1'b0, 0, 10'h280, 1'b1, 1'b0};

        // Reset
        rst = 1'b1;
        repeat (5) tick();
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_flags", {busy, done, err}, 3'b000);
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", {tx_ready, ps2_clk_oe, ps2_data_oe, busy}, 4'b1000);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
            repeat (10) tick();
        end

        // Device never clocks after release
        mon_clear();
        request(CMD_ENABLE, ok);
        w = 0;
        while (n_err == 0 && w < INHIBIT_CYCLES + START_HOLD + TIMEOUT_CYCLES + 200) begin
            tick();
            w++;
        end
        repeat (3) tick();
        check("tmo_err_cnt", n_err, 1);
        check("tmo_latency", t_err - t_rel, TIMEOUT_CYCLES);
        check("tmo_no_done", n_done, 0);
        check("tmo_released", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
        repeat (10) tick();

        // Reset at the fifth falling edge, then a normal send
        mon_clear();
        request(CMD_ENABLE, ok);
        device_xfer(1'b0, 0, 5, bits, started);
        repeat (20) tick();
        check("rst_xfer_no_done", n_done, 0);
        check("rst_xfer_no_err", n_err, 0);
        run_vec(vecs[0], 10);
        repeat (10) tick();

        // Clock glitch during SHIFT plus a request while busy
        mon_clear();
        exp_q.push_back(10'h2F4);
        request(CMD_ENABLE, ok);
        repeat (10) tick();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        check("busy_req_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        tx_data  = CMD_ENABLE;
        device_xfer(1'b0, 3, 0, bits, started);
        repeat (50) tick();
        exp_frame = exp_q.pop_front();
        check("glitch_frame", bits, exp_frame);
        check("glitch_done", n_done, 1);
        check("glitch_err", n_err, 0);
        check("busy_req_accepts", n_accept, 1);
        check("glitch_idle", {tx_ready, busy}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 mouse port; the other direction of the existing mouse receive path.
- Sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) with the full PS/2 request-to-send sequence and checks the device acknowledge.
- Runs in the 100 MHz domain alongside the mouse controller. Drives open-collector enables that the top level converts to the ps2_clk/ps2_data inouts (pull low when enable=1, else Z).

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles ps2_clk is held low before start (120 µs at 100 MHz).
- START_HOLD, 20, clk cycles data and clock are both low before clock is released.
- TIMEOUT_CYCLES, 2000000, max clk cycles from clock release to ack (20 ms); exceeding it is an error.
- FILTER_LEN, 8, consecutive equal samples needed to accept a ps2_clk level change.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw pad level of ps2_clk (asynchronous).
- ps2_data_in  in  1  raw pad level of ps2_data (asynchronous).
- ps2_clk_oe  out  1  1 = pull ps2_clk low.
- ps2_data_oe  out  1  1 = pull ps2_data low.
- busy  out  1  high from accept until DONE/ERR; the mouse receiver ignores the bus while high.
- done  out  1  one-cycle pulse, byte acknowledged.
- err  out  1  one-cycle pulse: no ack (ack bit = 1) or timeout.

Behaviour:
- Reset values: tx_ready=1, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, FSM=IDLE, all counters 0. Reset mid-transfer releases both lines on the next clk edge.
- Input conditioning: 2-FF synchronizer on both pad inputs. ps2_clk is filtered: the level changes only after FILTER_LEN equal samples. Falling edge = filtered 1->0 transition, one-cycle strobe.
- Accept: in IDLE with tx_valid=1, latch tx_data, compute parity = ~^tx_data (odd parity), go to INHIBIT. tx_ready drops the cycle after accept. tx_valid outside IDLE is ignored.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES.
- START: clk_oe=1, data_oe=1 (start bit 0) for START_HOLD cycles. Then clk_oe=0, keep data_oe=1, arm the timeout counter, go to SHIFT.
- SHIFT: 10-bit frame {stop=1, parity, data[7:0]} with bit index 0..9. On each filtered falling edge, drive frame[idx] (data_oe = ~bit) and increment idx.
  - Edge 1 presents data bit 0 (the start bit is already on the line).
  - Edge 8 presents data bit 7; edge 9 presents parity; edge 10 releases data (stop).
  - Then go to ACK.
- ACK: on the next (11th) falling edge, sample synchronized ps2_data. 0 -> WAIT_IDLE. 1 -> ERR.
- WAIT_IDLE: wait until filtered clk=1 and data=1, then DONE.
- DONE / ERR: one cycle, pulse done or err, both oe=0, return to IDLE. busy=0 in IDLE.
- Timeout: counter runs in SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to ERR from any of these states and releases both lines.
- No implicit retry; the caller decides whether to resend.
- Latency: done arrives at INHIBIT_CYCLES + START_HOLD + device clocking (~11 device periods) + filter delay.

Decomposition:
- Package ps2_pkg: FSM state enum {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE, ERR}, command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA.
- One sub-module: ps2_line_filter (2-FF synchronizer + FILTER_LEN glitch filter + falling-edge strobe), instantiated for ps2_clk. ps2_data uses the synchronizer only.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and acking.
  - Required: clk_oe high for exactly 12000 cycles, then data_oe low to high per bits 0,0,1,0,1,1,1,1.
  - Parity line level 0; stop released; one done pulse; err never asserted.
- Send 0xFF.
  - Required: parity line level 1; done pulse.
- Device ends with ack bit=1.
  - Required: one err pulse, no done, both oe=0, tx_ready=1 next cycle.
- Device never clocks after release.
  - Required: err pulse exactly TIMEOUT_CYCLES after clk_oe falls.
- Assert rst at falling edge 5.
  - Required: clk_oe=data_oe=0, busy=0, tx_ready=1 on the next clk; a new 0xF4 send then completes normally.
- 3-cycle glitch on ps2_clk during SHIFT, plus tx_valid pulsed while busy.
  - Required: no bit advance; second request ignored; transmitted byte unchanged.
